// File: rtl/cpu_run_controller_pkg.sv
// Shared types and defaults for the CPU run controller.
// State encoding is visible on o_State for the front-panel display.
package cpu_run_controller_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 24;

  localparam int DEF_RUN_DIV    = 500000;
  localparam int DEF_RST_CYCLES = 16;
  localparam int DEF_PC_W       = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RST_HOLD = 3'd0,
    ST_PAUSED   = 3'd1,
    ST_STEP     = 3'd2,
    ST_RUN      = 3'd3,
    ST_HALTED   = 3'd4
  } run_state_t;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Core-facing bundle: clock-enable/reset out, PC/halt back.
// master = run controller, slave = CPU core.
interface cpu_run_controller_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] i_PC;
  logic            i_Halt;
  logic            o_CPU_CE;
  logic            o_CPU_RST;

  modport master (
    input  i_PC,
    input  i_Halt,
    output o_CPU_CE,
    output o_CPU_RST
  );

  modport slave (
    output i_PC,
    output i_Halt,
    input  o_CPU_CE,
    input  o_CPU_RST
  );
endinterface

// File: rtl/cpu_run_controller_edge.sv
// Registered rising-edge detector for a debounced button level.
// One request per press, however long the level is held.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/halt/breakpoint sequencer producing the CPU clock-enable.
// Prescaler and FSM live here; button edges come from rise_edge_detect.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int RUN_DIV    = DEF_RUN_DIV,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int PC_W       = DEF_PC_W
) (
  input  logic               i_CLK,
  input  logic               i_RESET_n,
  input  logic               i_Step,
  input  logic               i_Run,
  input  logic               i_CPU_Reset,
  input  logic               i_BP_En,
  input  logic [PC_W-1:0]    i_BP_Addr,
  cpu_run_controller_if.master core,
  output logic [STATE_W-1:0] o_State,
  output logic               o_BP_Hit,
  output logic [15:0]        o_InstrCount
);

  localparam logic [PRESC_W-1:0] LAST =
    PRESC_W'(RUN_DIV - 1);
  localparam logic [CNT_W-1:0] RST_LOAD =
    CNT_W'(RST_CYCLES);

  logic step_req;
  logic run_req;
  logic rst_req;

  rise_edge_detect u_step (
    .clk   (i_CLK),
    .rst_n (i_RESET_n),
    .level (i_Step),
    .rise  (step_req)
  );

  rise_edge_detect u_run (
    .clk   (i_CLK),
    .rst_n (i_RESET_n),
    .level (i_Run),
    .rise  (run_req)
  );

  rise_edge_detect u_rst (
    .clk   (i_CLK),
    .rst_n (i_RESET_n),
    .level (i_CPU_Reset),
    .rise  (rst_req)
  );

  run_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic              ce, ce_nxt;
  logic              rst, rst_nxt;
  logic              bp_hit, bp_nxt;
  logic              skip, skip_nxt;
  logic [15:0]       instr, instr_nxt;
  logic              bp_match;

  assign bp_match = i_BP_En && (core.i_PC == i_BP_Addr);

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state  <= ST_RST_HOLD;
      cnt    <= RST_LOAD;
      presc  <= '0;
      ce     <= 1'b0;
      rst    <= 1'b1;
      bp_hit <= 1'b0;
      skip   <= 1'b0;
      instr  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      presc  <= presc_nxt;
      ce     <= ce_nxt;
      rst    <= rst_nxt;
      bp_hit <= bp_nxt;
      skip   <= skip_nxt;
      instr  <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    presc_nxt = presc;
    ce_nxt    = 1'b0;
    rst_nxt   = 1'b0;
    bp_nxt    = bp_hit;
    skip_nxt  = skip;
    instr_nxt = instr;
    if (ce && instr != 16'hFFFF)
      instr_nxt = instr + 16'd1;
    if (step_req || run_req)
      bp_nxt = 1'b0;
    if (rst_req) begin
      state_nxt = ST_RST_HOLD;
      cnt_nxt   = RST_LOAD;
      rst_nxt   = 1'b1;
      bp_nxt    = 1'b0;
      instr_nxt = '0;
    end else begin
      unique case (state)
        ST_RST_HOLD: begin
          if (cnt <= 8'd1) begin
            state_nxt = ST_PAUSED;
          end else begin
            cnt_nxt = cnt - 8'd1;
            rst_nxt = 1'b1;
          end
        end
        ST_PAUSED: begin
          // skip arms a free pass past the breakpoint for the next CE
          if (run_req) begin
            state_nxt = ST_RUN;
            presc_nxt = '0;
            skip_nxt  = 1'b1;
          end else if (step_req) begin
            state_nxt = ST_STEP;
            skip_nxt  = 1'b1;
          end
        end
        ST_STEP: begin
          state_nxt = ST_PAUSED;
          if (core.i_Halt) begin
            state_nxt = ST_HALTED;
          end else if (bp_match && !skip) begin
            bp_nxt = 1'b1;
          end else begin
            ce_nxt   = 1'b1;
            skip_nxt = 1'b0;
          end
        end
        ST_RUN: begin
          if (run_req) begin
            state_nxt = ST_PAUSED;
          end else if (core.i_Halt) begin
            state_nxt = ST_HALTED;
          end else if (presc == LAST) begin
            presc_nxt = '0;
            if (bp_match && !skip) begin
              state_nxt = ST_PAUSED;
              bp_nxt    = 1'b1;
            end else begin
              ce_nxt   = 1'b1;
              skip_nxt = 1'b0;
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        ST_HALTED: begin
          state_nxt = ST_HALTED;
        end
        default: begin
          state_nxt = ST_RST_HOLD;
          cnt_nxt   = RST_LOAD;
          rst_nxt   = 1'b1;
        end
      endcase
    end
  end

  assign core.o_CPU_CE  = ce;
  assign core.o_CPU_RST = rst;
  assign o_State        = state;
  assign o_BP_Hit       = bp_hit;
  assign o_InstrCount   = instr;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed + random bench for cpu_run_controller against a
// cycle-level behavioural model of the run/step/halt rules.
module tb_cpu_run_controller;

  localparam int RUN_DIV    = 4;
  localparam int RST_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic        run;
  logic        crst;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [2:0]  o_state;
  logic        o_bp;
  logic [15:0] o_instr;

  cpu_run_controller_if #(.PC_W(8)) core_if ();

  cpu_run_controller #(
    .RUN_DIV    (RUN_DIV),
    .RST_CYCLES (RST_CYCLES),
    .PC_W       (8)
  ) dut (
    .i_CLK        (clk),
    .i_RESET_n    (rst_n),
    .i_Step       (step),
    .i_Run        (run),
    .i_CPU_Reset  (crst),
    .i_BP_En      (bp_en),
    .i_BP_Addr    (bp_addr),
    .core         (core_if),
    .o_State      (o_state),
    .o_BP_Hit     (o_bp),
    .o_InstrCount (o_instr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model: mode uses the published o_State numbering
  int m_mode;
  int m_left;
  int m_tick;
  int m_instr;
  bit m_ce;
  bit m_bp;
  bit m_fresh;
  bit p_step, p_run, p_crst;
  bit pc_follow;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit sr, rr, cr, hit;
    if (!rst_n) begin
      m_mode = 0; m_left = RST_CYCLES;
      m_ce = 0; m_bp = 0; m_instr = 0;
      m_fresh = 0;
      p_step = 0; p_run = 0; p_crst = 0;
      return;
    end
    sr = step && !p_step;
    rr = run && !p_run;
    cr = crst && !p_crst;
    p_step = step; p_run = run; p_crst = crst;
    hit = bp_en && (core_if.i_PC == bp_addr) && !m_fresh;
    if (m_ce && m_instr < 65535) m_instr++;
    m_ce = 0;
    if (sr || rr) m_bp = 0;
    if (cr) begin
      m_mode = 0; m_left = RST_CYCLES;
      m_bp = 0; m_instr = 0;
    end else if (m_mode == 0) begin
      m_left--;
      if (m_left == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rr) begin
        m_mode = 3; m_tick = 0; m_fresh = 1;
      end else if (sr) begin
        m_mode = 2; m_fresh = 1;
      end
    end else if (m_mode == 2) begin
      m_mode = core_if.i_Halt ? 4 : 1;
      if (!core_if.i_Halt) begin
        if (hit) m_bp = 1;
        else begin m_ce = 1; m_fresh = 0; end
      end
    end else if (m_mode == 3) begin
      if (rr) m_mode = 1;
      else if (core_if.i_Halt) m_mode = 4;
      else begin
        m_tick++;
        if (m_tick == RUN_DIV) begin
          m_tick = 0;
          if (hit) begin m_mode = 1; m_bp = 1; end
          else begin m_ce = 1; m_fresh = 0; end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ce", core_if.o_CPU_CE, m_ce);
    chk("rst", core_if.o_CPU_RST, m_mode == 0);
    chk("state", o_state, m_mode);
    chk("bp_hit", o_bp, m_bp);
    chk("instr", o_instr, m_instr);
    if (pc_follow && m_ce) core_if.i_PC = core_if.i_PC + 8'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n, first;
    rst_n = 0; step = 0; run = 0; crst = 0;
    bp_en = 0; bp_addr = 8'h00;
    core_if.i_PC = 8'h00; core_if.i_Halt = 1'b0;
    pc_follow = 0;
    idle(2);
    chk("reset_state", o_state, 0);
    chk("reset_rst", core_if.o_CPU_RST, 1);
    chk("reset_instr", o_instr, 0);

    // reset width after release
    rst_n = 1; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (core_if.o_CPU_RST === 1'b1) n++;
      cycle();
    end
    chk("rst_width", n, RST_CYCLES);
    chk("paused", o_state, 1);
    chk("paused_ce", core_if.o_CPU_CE, 0);

    // single step with the button held
    step = 1; n = 0; first = 0;
    for (int i = 1; i <= 100; i++) begin
      cycle();
      if (core_if.o_CPU_CE === 1'b1) begin
        n++;
        if (first == 0) first = i;
      end
    end
    step = 0;
    cycle();
    chk("step_pulses", n, 1);
    chk("step_latency", first, 2);
    chk("step_instr", o_instr, 1);

    // free run, then pause
    run = 1; cycle(); run = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (core_if.o_CPU_CE === 1'b1) n++;
    end
    chk("run_pulses", (n >= 9 && n <= 11), 1);
    run = 1; cycle(); run = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (core_if.o_CPU_CE === 1'b1) n++;
    end
    chk("pause_pulses", n, 0);
    chk("pause_state", o_state, 1);

    // breakpoint at 5, then step off it
    crst = 1; cycle(); crst = 0;
    idle(20);
    chk("crst_instr", o_instr, 0);
    bp_en = 1; bp_addr = 8'h05;
    core_if.i_PC = 8'h00; pc_follow = 1;
    run = 1; cycle(); run = 0;
    idle(40);
    chk("bp_pc", core_if.i_PC, 8'h05);
    chk("bp_flag", o_bp, 1);
    chk("bp_instr", o_instr, 5);
    chk("bp_state", o_state, 1);
    step = 1; cycle(); step = 0;
    idle(5);
    chk("bp_step_pc", core_if.i_PC, 8'h06);
    chk("bp_step_flag", o_bp, 0);
    chk("bp_step_instr", o_instr, 6);

    // halt while running
    bp_en = 0;
    run = 1; cycle(); run = 0;
    idle(6);
    core_if.i_Halt = 1'b1; n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (core_if.o_CPU_CE === 1'b1) n++;
    end
    step = 1; cycle(); step = 0; cycle();
    run = 1; cycle(); run = 0; cycle();
    if (core_if.o_CPU_CE === 1'b1) n++;
    chk("halt_state", o_state, 4);
    chk("halt_pulses", n, 0);
    crst = 1; cycle(); crst = 0;
    chk("halt_exit", o_state, 0);
    chk("halt_instr", o_instr, 0);
    core_if.i_Halt = 1'b0;
    idle(20);

    // simultaneous requests
    step = 1; run = 1; cycle();
    chk("step_run", o_state, 3);
    step = 0; run = 0; cycle();
    crst = 1; run = 1; cycle();
    chk("crst_run", o_state, 0);
    crst = 0; run = 0;
    idle(20);

    // random soak
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) step = ~step;
      if ($urandom_range(7) == 0) run = ~run;
      if ($urandom_range(39) == 0) crst = ~crst;
      core_if.i_Halt = ($urandom_range(23) == 0);
      bp_en = 1'($urandom_range(1));
      bp_addr = 8'($urandom_range(7));
      if ($urandom_range(31) == 0)
        core_if.i_PC = 8'($urandom_range(7));
      rst_n = ($urandom_range(249) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the Microcontroller core: generates a single-cycle clock-enable for the CPU so the core runs on the system clock rather than a debounced button.
- Supports single-step, free-run at a prescaled rate, halt on HLT and PC breakpoint, and a timed CPU reset.
- Sits between the debounced front-panel switches/DIPs and the Microcontroller; exposes run state to the LED/7-segment drivers.

Parameters:
- RUN_DIV, 500000, i_CLK cycles between CE pulses in RUN (range 2..2^24-1).
- RST_CYCLES, 16, cycles o_CPU_RST is held after a reset request (range 1..255).
- PC_W, 8, program counter width.

Ports:
- i_CLK  in  1  system clock (5 MHz domain).
- i_RESET_n  in  1  synchronous active-low reset.
- i_Step  in  1  debounced step button level, active-high; rising edge = step request.
- i_Run  in  1  debounced run/pause button level; rising edge toggles run.
- i_CPU_Reset  in  1  debounced CPU-reset button level; rising edge = reset request.
- i_BP_En  in  1  breakpoint enable (DIP).
- i_BP_Addr  in  PC_W  breakpoint address (DIP).
- i_PC  in  PC_W  current PC from the core.
- i_Halt  in  1  core decoded HLT, level.
- o_CPU_CE  out  1  one-cycle CPU clock-enable pulse.
- o_CPU_RST  out  1  CPU reset, active-high.
- o_State  out  3  current FSM state encoding.
- o_BP_Hit  out  1  sticky breakpoint-hit flag.
- o_InstrCount  out  16  instructions executed since last CPU reset.

Behaviour:
- The entire block is reset when i_RESET_n=0 at a rising edge of i_CLK: state=RST_HOLD, counter loaded with RST_CYCLES, o_CPU_RST=1, o_CPU_CE=0, o_BP_Hit=0, o_InstrCount=0, edge registers=0.
- Edge detection: one register per button input; a request equals the level AND NOT the previous level. Only one pulse is produced per press.
- States (o_State encoding): RST_HOLD=0, PAUSED=1, STEP=2, RUN=3, HALTED=4.
- RST_HOLD: o_CPU_RST=1 and the counter decrements. At counter==1 go to PAUSED the next cycle, with o_CPU_RST=0. Total reset width is exactly RST_CYCLES cycles.
- PAUSED:
  - A step request goes to STEP.
  - A run request goes to RUN with the prescaler cleared.
  - If both occur in the same cycle, run wins.
- STEP: assert o_CPU_CE for exactly 1 cycle, then return to PAUSED. Latency from the step edge to CE is 2 cycles (edge register, then STEP state).
- RUN:
  - The prescaler counts 0..RUN_DIV-1. When it reaches RUN_DIV-1, o_CPU_CE=1 for one cycle and the prescaler wraps to 0.
  - A run request goes to PAUSED; a pending CE in that cycle is suppressed.
- Stop conditions (evaluated in RUN and STEP before issuing CE):
  - i_Halt=1 goes to HALTED with no CE.
  - i_BP_En=1 and i_PC==i_BP_Addr goes to PAUSED with o_BP_Hit=1 and no CE.
  - Exception: the breakpoint check is skipped for the first CE after leaving PAUSED, so the user can step or run off a breakpoint.
- HALTED: CE is never issued. Step and run requests are ignored; only a CPU-reset request leaves this state.
- A CPU-reset request from any state goes to RST_HOLD: reload the counter, clear o_BP_Hit and o_InstrCount. A reset request in the same cycle as any other request has priority.
- o_InstrCount increments on every cycle with o_CPU_CE=1 and saturates at 16'hFFFF.
- o_BP_Hit clears on the next step or run request, or on CPU reset.
- All outputs are registered; o_CPU_CE is never high while o_CPU_RST=1.

Decomposition:
- Shared package holds:
  - the state encoding constants (ST_RST_HOLD..ST_HALTED);
  - the 3-bit state width;
  - default RUN_DIV/RST_CYCLES values used by top.
- One natural sub-module, `rise_edge_detect`: a 1-bit registered edge detector, instantiated three times.
- The prescaler and FSM stay in the parent.

Test Plan:
- Assert i_RESET_n=0 for 2 cycles, then release with RST_CYCLES=16 -> o_CPU_RST high for exactly 16 cycles, then o_State=1 and o_CPU_CE=0.
- From PAUSED, raise i_Step once and hold it high for 100 cycles -> exactly one o_CPU_CE pulse, 2 cycles after the edge; o_InstrCount=1.
- RUN_DIV=4: press i_Run, then run 40 cycles -> a CE every 4th cycle (10 pulses ±1 at the boundary); press i_Run again -> no further CE, o_State=1.
- RUN with i_BP_En=1, i_BP_Addr=8'h05, PC incremented by the bench on each CE from 0 -> stops with i_PC=5, o_BP_Hit=1, o_InstrCount=5; a step then gives one CE, i_PC=6, o_BP_Hit=0.
- In RUN, assert i_Halt -> HALTED with no CE; step/run presses ignored; i_CPU_Reset edge -> RST_HOLD, o_InstrCount=0.
- Step and run edges in the same cycle from PAUSED -> RUN; a CPU-reset edge together with run -> RST_HOLD.
